// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction-memory program loader with length header and XOR checksum
//
// Accepts a byte stream (len_hi, len_lo, 4*N payload bytes MSB first, checksum),
// writes each assembled big-endian word to consecutive word-aligned addresses and
// releases the core from reset only after a load completes with a good checksum.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             begin a load (honoured in IDLE/DONE/ERROR only)
//   in_data/in_valid  stream byte and its valid; in_ready is the accept side
//   imem_we/addr/wdata one-cycle registered write per assembled word
//   cpu_reset         low only in DONE
//   busy/done/error   load progress and outcome
//   words_written     words written by the current or last load

module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest legal word count; a header above this cannot fit in memory.
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

    state_t                 state_q;
    logic [7:0]             len_hi_q;
    logic [15:0]            len_q;
    logic [23:0]            shift_q;
    logic [7:0]             acc_q;
    logic [1:0]             byte_idx_q;
    logic [ADDR_WIDTH-1:0]  word_idx_q;
    logic [ADDR_WIDTH:0]    words_written_q;
    logic                   imem_we_q;
    logic [31:0]            imem_addr_q;
    logic [31:0]            imem_wdata_q;
    logic                   cpu_reset_q;
    logic                   done_q;
    logic                   error_q;

    logic                   xfer;
    logic [15:0]            len_d;
    logic [31:0]            word_d;
    logic                   last_word_d;

    assign busy     = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
    assign in_ready = busy;
    assign xfer     = in_valid && in_ready;

    assign len_d       = {len_hi_q, in_data};
    assign word_d      = {shift_q, in_data};
    // True when the word being completed is the N-th one of the header count.
    assign last_word_d = (17'(words_written_q) + 17'd1) == {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            len_hi_q        <= '0;
            len_q           <= '0;
            shift_q         <= '0;
            acc_q           <= '0;
            byte_idx_q      <= '0;
            word_idx_q      <= '0;
            words_written_q <= '0;
            imem_we_q       <= 1'b0;
            imem_addr_q     <= '0;
            imem_wdata_q    <= '0;
            cpu_reset_q     <= 1'b1;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            imem_we_q <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q         <= S_LEN_HI;
                        done_q          <= 1'b0;
                        error_q         <= 1'b0;
                        acc_q           <= '0;
                        byte_idx_q      <= '0;
                        word_idx_q      <= '0;
                        words_written_q <= '0;
                        cpu_reset_q     <= 1'b1;
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        len_hi_q <= in_data;
                        state_q  <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (xfer) begin
                        len_q <= len_d;
                        if ({1'b0, len_d} > CAPACITY) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        shift_q    <= word_d[23:0];
                        acc_q      <= acc_q ^ in_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            imem_we_q       <= 1'b1;
                            imem_addr_q     <= {{(30 - ADDR_WIDTH){1'b0}}, word_idx_q, 2'b00};
                            imem_wdata_q    <= word_d;
                            word_idx_q      <= word_idx_q + 1'b1;
                            words_written_q <= words_written_q + 1'b1;
                            if (last_word_d) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                end

                S_CHECK: begin
                    if (xfer) begin
                        if (in_data == acc_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_we       = imem_we_q;
    assign imem_addr     = imem_addr_q;
    assign imem_wdata    = imem_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard testbench for imem_loader

module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_written;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            hs_cnt  = 0;
    int            wr_cnt  = 0;
    logic [63:0]   sb[$];
    logic [31:0]   words[0:1];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (in_valid === 1'b1 && in_ready === 1'b1) hs_cnt++;
        if (imem_we === 1'b1) begin
            wr_cnt++;
            check("unexpected_we", 64'(sb.size() == 0), 64'd0);
            if (sb.size() != 0) begin
                logic [63:0] e;
                e = sb.pop_front();
                check("we_addr", 64'(imem_addr), 64'(e[63:32]));
                check("we_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int bound;
        bound    = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && bound < 50) begin
            tick(1);
            bound++;
        end
        if (bound >= 50) check("ready_timeout", 64'd0, 64'd1);
        tick(1);
        in_valid = 1'b0;
        tick(gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Sends a header of nw words, the payload from words[], and the checksum
    // XOR cmod; stops after stop_after bytes when stop_after >= 0.
    task automatic load(input int nw, input logic [7:0] cmod, input int gap, input int stop_after);
        logic [7:0]  q[$];
        logic [7:0]  x;
        logic [31:0] w;
        logic [15:0] n16;
        x   = 8'h00;
        n16 = 16'(nw);
        q.push_back(n16[15:8]);
        q.push_back(n16[7:0]);
        for (int i = 0; i < nw; i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                q.push_back(w[31 - 8 * j -: 8]);
                x = x ^ w[31 - 8 * j -: 8];
            end
        end
        q.push_back(x ^ cmod);
        for (int k = 0; k < q.size(); k++) begin
            if (stop_after >= 0 && k >= stop_after) break;
            if (k >= 2 && k < 2 + 4 * nw && ((k - 2) % 4) == 3)
                sb.push_back({32'(((k - 2) / 4) * 4), words[(k - 2) / 4]});
            send_byte(q[k], gap);
        end
    endtask

    task automatic check_final(input string tag, input logic d, input logic e, input logic cr,
                               input int ww);
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_error"}, 64'(error), 64'(e));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(cr));
        check({tag, "_ww"}, 64'(words_written), 64'(ww));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        words[0] = 32'h12345678;
        words[1] = 32'h9ABCDEF0;

        // 1: reset with start and in_valid asserted
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        tick(2);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check_final("rst", 1'b0, 1'b0, 1'b1, 0);
        check("rst_writes", 64'(wr_cnt), 64'd0);

        // 2: good two-word load, back to back
        pulse_start();
        check("s2_busy", 64'(busy), 64'd1);
        hs_cnt = 0;
        load(2, 8'h00, 0, -1);
        tick(2);
        check_final("s2", 1'b1, 1'b0, 1'b0, 2);
        check("s2_hs", 64'(hs_cnt), 64'd11);
        check("s2_sb_empty", 64'(sb.size()), 64'd0);

        // 3: bad checksum, started from DONE
        pulse_start();
        check("s3_cpu_reset_start", 64'(cpu_reset), 64'd1);
        check("s3_done_cleared", 64'(done), 64'd0);
        load(2, 8'h01, 0, -1);
        tick(2);
        check_final("s3", 1'b0, 1'b1, 1'b1, 2);
        check("s3_sb_empty", 64'(sb.size()), 64'd0);

        // 4: two idle cycles between bytes; a start while busy is ignored
        pulse_start();
        pulse_start();
        check("s4_busy_after_start", 64'(busy), 64'd1);
        hs_cnt = 0;
        load(2, 8'h00, 2, -1);
        tick(2);
        check_final("s4", 1'b1, 1'b0, 1'b0, 2);
        check("s4_hs", 64'(hs_cnt), 64'd11);
        check("s4_sb_empty", 64'(sb.size()), 64'd0);

        // 5: oversize header, then a zero-length load
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("s5_err", 64'(error), 64'd1);
        check("s5_ready", 64'(in_ready), 64'd0);
        tick(3);
        check_final("s5a", 1'b0, 1'b1, 1'b1, 0);
        pulse_start();
        load(0, 8'h00, 0, -1);
        tick(2);
        check_final("s5b", 1'b1, 1'b0, 1'b0, 0);
        check("s5_writes", 64'(wr_cnt), 64'd0);

        // 6: reset after six bytes, then a full reload
        wr_cnt = 0;
        pulse_start();
        load(2, 8'h00, 0, 6);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("s6_writes", 64'(wr_cnt), 64'd1);
        check("s6_sb_empty", 64'(sb.size()), 64'd0);
        check("s6_we", 64'(imem_we), 64'd0);
        check("s6_addr", 64'(imem_addr), 64'd0);
        check("s6_wdata", 64'(imem_wdata), 64'd0);
        check_final("s6_rst", 1'b0, 1'b0, 1'b1, 0);
        pulse_start();
        load(2, 8'h00, 0, -1);
        tick(2);
        check_final("s6_reload", 1'b1, 1'b0, 1'b0, 2);
        check("s6_total_writes", 64'(wr_cnt), 64'd3);
        check("s6_sb_final", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
